mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, loader wait cycles before loader overrides CPU priority (range 1..15).
REQ-002 clock  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 cpu_req  in  1  CPU data-memory access request this cycle.
REQ-005 cpu_we  in  1  CPU write enable (1 = store, 0 = load).
REQ-006 cpu_addr  in  32  CPU byte address.
REQ-007 cpu_wdata  in  32  CPU store data.
REQ-008 cpu_stall  out  1  CPU access not granted this cycle; CPU must hold its request.
REQ-009 cpu_rdata  out  32  load data returned to CPU.
REQ-010 cpu_rvalid  out  1  cpu_rdata valid this cycle.
REQ-011 ld_req  in  1  loader/debug port request; held with addr/data until ld_gnt.
REQ-012 ld_we  in  1  loader write enable.
REQ-013 ld_addr  in  32  loader byte address.
REQ-014 ld_wdata  in  32  loader write data.
REQ-015 ld_gnt  out  1  one-cycle pulse: loader access issued this cycle.
REQ-016 ld_rdata  out  32  read data returned to loader.
REQ-017 ld_rvalid  out  1  ld_rdata valid this cycle.
REQ-018 mem_en  out  1  memory access issued this cycle.
REQ-019 mem_we  out  1  memory write strobe.
REQ-020 mem_addr  out  32  memory address.
REQ-021 mem_wdata  out  32  memory write data.
REQ-022 mem_rdata  in  32  synchronous memory read data, valid one cycle after a read issue.

Function
REQ-023 At most one requester SHALL be granted per cycle; the grant decision is combinational from cpu_req, ld_req and the starvation counter.
REQ-024 Default priority: CPU wins when both request and starve_cnt < STARVE_LIMIT.
REQ-025 starve_cnt SHALL increment each cycle ld_req=1 and loader not granted, saturating at STARVE_LIMIT; it SHALL clear on ld_gnt or when ld_req=0.
REQ-026 When starve_cnt == STARVE_LIMIT and ld_req=1, the loader SHALL win regardless of cpu_req.
REQ-027 cpu_stall SHALL equal cpu_req AND NOT CPU-granted; cpu_stall SHALL be 0 when cpu_req=0.
REQ-028 Winner's addr/wdata/we SHALL drive mem_addr/mem_wdata/mem_we combinationally with mem_en=1; with no winner mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-029 Owner state machine (registered), states IDLE, CPU_RD, LD_RD: next state CPU_RD on granted CPU read, LD_RD on granted loader read, IDLE otherwise (including any write).
REQ-030 In CPU_RD: cpu_rvalid=1, cpu_rdata=mem_rdata; in LD_RD: ld_rvalid=1, ld_rdata=mem_rdata; rdata outputs of the non-owner SHALL be 0.
REQ-031 Read latency: rvalid asserts exactly one cycle after the grant cycle; writes complete in the grant cycle and produce no rvalid.
REQ-032 Back-to-back grants (any mix, any requester) SHALL be accepted every cycle without bubbles.
REQ-033 ld_req withdrawn before grant: no access issued, starve_cnt cleared next cycle.
REQ-034 Addresses and data SHALL pass unmodified; alignment is the requester's responsibility.

Reset
REQ-035 On reset assertion, immediately: state=IDLE, starve_cnt=0, cpu_rvalid=0, ld_rvalid=0, cpu_rdata=0, ld_rdata=0.
REQ-036 Combinational outputs during reset SHALL be forced inactive: mem_en=0, mem_we=0, ld_gnt=0, cpu_stall=cpu_req.
REQ-037 A read granted in the cycle before reset SHALL NOT produce rvalid after reset release.

Structure
REQ-038 Shared package SHALL hold the owner-state encoding (IDLE=2'd0, CPU_RD=2'd1, LD_RD=2'd2) and the default STARVE_LIMIT constant.
REQ-039 Single module, no sub-modules; starve_cnt is 4 bits.

Verification
REQ-040 CPU read 0x10 alone, mem returns 0xDEADBEEF -> mem_en=1 cycle 0, cpu_rvalid=1 with 0xDEADBEEF cycle 1, cpu_stall=0.
REQ-041 cpu_req and ld_req held continuously, STARVE_LIMIT=4 -> CPU granted 4 cycles, cpu_stall=1 and ld_gnt=1 in cycle 5, CPU granted again in cycle 6.
REQ-042 Loader write 0x20/0x12345678 with CPU idle -> ld_gnt=1 same cycle, mem_we=1, mem_addr=0x20, no ld_rvalid.
REQ-043 Alternating CPU read then loader read on consecutive cycles -> cpu_rvalid then ld_rvalid on consecutive cycles, data routed to correct port only.
REQ-044 Reset asserted in cycle following a granted CPU read -> cpu_rvalid=0 immediately, state IDLE, starve_cnt=0.
REQ-045 ld_req raised 2 cycles then dropped while CPU busy -> no ld_gnt, starve_cnt returns to 0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the CPU/loader memory arbiter: owner-state
// encoding and the default loader starvation limit.
package mem_arbiter_pkg;

  // Which requester owns the read data returning this cycle
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CPU_RD = 2'd1,
    LD_RD  = 2'd2
  } owner_e;

  // Loader wait cycles tolerated before it overrides CPU priority
  localparam int STARVE_LIMIT_DEFAULT = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one synchronous single-port memory between the
// CPU data port and a loader/debug port. The CPU has priority unless the
// loader has waited STARVE_LIMIT cycles. Read data returns one cycle after
// the grant and is routed only to the requester that issued the read.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  // CPU data port
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_stall,
  output logic [31:0] cpu_rdata,
  output logic        cpu_rvalid,
  // Loader / debug port
  input  logic        ld_req,
  input  logic        ld_we,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_wdata,
  output logic        ld_gnt,
  output logic [31:0] ld_rdata,
  output logic        ld_rvalid,
  // Memory port
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;
  owner_e     state;
  logic       cpu_gnt;
  logic       ld_win;

  // Grant decision; reset holds both grants low so no access escapes
  always_comb begin
    ld_win  = 1'b0;
    cpu_gnt = 1'b0;
    if (!reset) begin
      ld_win  = ld_req && (!cpu_req || (starve_cnt == LIMIT));
      cpu_gnt = cpu_req && !ld_win;
    end
  end

  assign ld_gnt    = ld_win;
  assign cpu_stall = cpu_req && !cpu_gnt;

  // Steer the winner's request onto the memory port, zeros when idle
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (ld_win) begin
      mem_en    = 1'b1;
      mem_we    = ld_we;
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
    end
  end

  // Loader wait counter: counts ungranted request cycles, saturating
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!ld_req || ld_win) begin
      starve_cnt <= '0;
    end else if (starve_cnt < LIMIT) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Owner FSM: remembers who issued last cycle's read so data goes back to it
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else if (cpu_gnt && !cpu_we) begin
      state <= CPU_RD;
    end else if (ld_win && !ld_we) begin
      state <= LD_RD;
    end else begin
      state <= IDLE;
    end
  end

  assign cpu_rvalid = (state == CPU_RD);
  assign ld_rvalid  = (state == LD_RD);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign ld_rdata   = ld_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter. Inputs change on the falling edge,
// outputs are sampled 1 ns later, well away from the rising edge.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_stall, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        ld_req, ld_we;
  logic [31:0] ld_addr, ld_wdata;
  logic        ld_gnt, ld_rvalid;
  logic [31:0] ld_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_stall (cpu_stall),
    .cpu_rdata (cpu_rdata),
    .cpu_rvalid(cpu_rvalid),
    .ld_req    (ld_req),
    .ld_we     (ld_we),
    .ld_addr   (ld_addr),
    .ld_wdata  (ld_wdata),
    .ld_gnt    (ld_gnt),
    .ld_rdata  (ld_rdata),
    .ld_rvalid (ld_rvalid),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    ld_req = 0;  ld_we = 0;  ld_addr = 0;  ld_wdata = 0;
    mem_rdata = 0;
  endtask

  task automatic next_cycle();
    @(negedge clock);
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; cpu_req = 1; ld_req = 1; ld_we = 1; mem_rdata = 32'hCAFEF00D;
    next_cycle(); #1;
    $display("reset: cpu_req=1 ld_req=1 during reset");
    checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL rst_mem_en got=%b exp=0", mem_en); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
    checks++; if (ld_gnt !== 1'b0) begin failures++; $display("FAIL rst_ld_gnt got=%b exp=0", ld_gnt); end
    checks++; if (cpu_stall !== 1'b1) begin failures++; $display("FAIL rst_cpu_stall got=%b exp=1", cpu_stall); end
    checks++; if (cpu_rvalid !== 1'b0 || ld_rvalid !== 1'b0) begin failures++; $display("FAIL rst_rvalid got=%b%b exp=00", cpu_rvalid, ld_rvalid); end
    checks++; if (cpu_rdata !== 32'h0 || ld_rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h/%h exp=0/0", cpu_rdata, ld_rdata); end
    idle_inputs();
    next_cycle();
    reset = 0;
    next_cycle();
  endtask

  task automatic test_cpu_read();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    #1;
    $display("cpu read addr=%h", cpu_addr);
    checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0) begin failures++; $display("FAIL cpurd_issue got en=%b we=%b exp en=1 we=0", mem_en, mem_we); end
    checks++; if (mem_addr !== 32'h10) begin failures++; $display("FAIL cpurd_addr got=%h exp=00000010", mem_addr); end
    checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL cpurd_stall got=%b exp=0", cpu_stall); end
    checks++; if (cpu_rvalid !== 1'b0) begin failures++; $display("FAIL cpurd_early_rvalid got=%b exp=0", cpu_rvalid); end
    next_cycle();
    idle_inputs(); mem_rdata = 32'hDEADBEEF;
    #1;
    checks++; if (cpu_rvalid !== 1'b1) begin failures++; $display("FAIL cpurd_rvalid got=%b exp=1", cpu_rvalid); end
    checks++; if (cpu_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL cpurd_data got=%h exp=deadbeef", cpu_rdata); end
    checks++; if (ld_rvalid !== 1'b0 || ld_rdata !== 32'h0) begin failures++; $display("FAIL cpurd_ld_side got=%b/%h exp=0/0", ld_rvalid, ld_rdata); end
    checks++; if (mem_en !== 1'b0 || mem_addr !== 32'h0) begin failures++; $display("FAIL cpurd_idle_mem got=%b/%h exp=0/0", mem_en, mem_addr); end
    next_cycle(); #1;
    checks++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'h0) begin failures++; $display("FAIL cpurd_rvalid_drop got=%b/%h exp=0/0", cpu_rvalid, cpu_rdata); end
    next_cycle();
  endtask

  task automatic test_starvation();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
    ld_req = 1;  ld_we = 1;  ld_addr = 32'h44; ld_wdata = 32'h0BADF00D;
    for (int c = 1; c <= 6; c++) begin
      logic exp_ld;
      exp_ld = (c == 5);
      #1;
      $display("starve cycle %0d: ld_gnt=%b cpu_stall=%b addr=%h", c, ld_gnt, cpu_stall, mem_addr);
      checks++; if (ld_gnt !== exp_ld) begin failures++; $display("FAIL starve_ld_gnt c%0d got=%b exp=%b", c, ld_gnt, exp_ld); end
      checks++; if (cpu_stall !== exp_ld) begin failures++; $display("FAIL starve_cpu_stall c%0d got=%b exp=%b", c, cpu_stall, exp_ld); end
      checks++; if (mem_addr !== (exp_ld ? 32'h44 : 32'h40)) begin failures++; $display("FAIL starve_addr c%0d got=%h exp=%h", c, mem_addr, exp_ld ? 32'h44 : 32'h40); end
      if (exp_ld) begin
        checks++; if (mem_we !== 1'b1 || mem_wdata !== 32'h0BADF00D) begin failures++; $display("FAIL starve_ld_wr got=%b/%h exp=1/0badf00d", mem_we, mem_wdata); end
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_loader_write();
    ld_req = 1; ld_we = 1; ld_addr = 32'h20; ld_wdata = 32'h12345678;
    #1;
    $display("loader write addr=%h data=%h", ld_addr, ld_wdata);
    checks++; if (ld_gnt !== 1'b1) begin failures++; $display("FAIL ldwr_gnt got=%b exp=1", ld_gnt); end
    checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1) begin failures++; $display("FAIL ldwr_strobe got en=%b we=%b exp=1/1", mem_en, mem_we); end
    checks++; if (mem_addr !== 32'h20 || mem_wdata !== 32'h12345678) begin failures++; $display("FAIL ldwr_bus got=%h/%h exp=00000020/12345678", mem_addr, mem_wdata); end
    next_cycle();
    idle_inputs(); mem_rdata = 32'h11112222;
    #1;
    checks++; if (ld_rvalid !== 1'b0 || ld_rdata !== 32'h0) begin failures++; $display("FAIL ldwr_no_rvalid got=%b/%h exp=0/0", ld_rvalid, ld_rdata); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100;
    #1;
    $display("b2b: cpu read %h", cpu_addr);
    checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h100) begin failures++; $display("FAIL b2b_cpu_issue got=%b/%h exp=1/00000100", mem_en, mem_addr); end
    next_cycle();
    idle_inputs();
    ld_req = 1; ld_we = 0; ld_addr = 32'h200; mem_rdata = 32'hAAAA5555;
    #1;
    $display("b2b: loader read %h", ld_addr);
    checks++; if (ld_gnt !== 1'b1 || mem_en !== 1'b1 || mem_addr !== 32'h200) begin failures++; $display("FAIL b2b_ld_issue got=%b/%b/%h exp=1/1/00000200", ld_gnt, mem_en, mem_addr); end
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hAAAA5555) begin failures++; $display("FAIL b2b_cpu_data got=%b/%h exp=1/aaaa5555", cpu_rvalid, cpu_rdata); end
    checks++; if (ld_rvalid !== 1'b0 || ld_rdata !== 32'h0) begin failures++; $display("FAIL b2b_ld_quiet got=%b/%h exp=0/0", ld_rvalid, ld_rdata); end
    next_cycle();
    idle_inputs(); mem_rdata = 32'h5555AAAA;
    #1;
    checks++; if (ld_rvalid !== 1'b1 || ld_rdata !== 32'h5555AAAA) begin failures++; $display("FAIL b2b_ld_data got=%b/%h exp=1/5555aaaa", ld_rvalid, ld_rdata); end
    checks++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'h0) begin failures++; $display("FAIL b2b_cpu_quiet got=%b/%h exp=0/0", cpu_rvalid, cpu_rdata); end
    next_cycle();
  endtask

  task automatic test_reset_after_read();
    // Build up loader wait count, then reset right after a granted CPU read
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h300; ld_req = 1; ld_we = 1; ld_addr = 32'h304;
    next_cycle();
    next_cycle();
    @(posedge clock); #2;
    reset = 1; mem_rdata = 32'h77778888;
    #1;
    $display("reset after cpu read");
    checks++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'h0) begin failures++; $display("FAIL rstrd_rvalid got=%b/%h exp=0/0", cpu_rvalid, cpu_rdata); end
    checks++; if (mem_en !== 1'b0 || cpu_stall !== 1'b1) begin failures++; $display("FAIL rstrd_forced got en=%b stall=%b exp=0/1", mem_en, cpu_stall); end
    next_cycle();
    reset = 0;
    #1;
    checks++; if (cpu_rvalid !== 1'b0) begin failures++; $display("FAIL rstrd_post_rvalid got=%b exp=0", cpu_rvalid); end
    // Counter restarted from zero: loader waits four full cycles again
    for (int c = 1; c <= 5; c++) begin
      checks++; if (ld_gnt !== (c == 5)) begin failures++; $display("FAIL rstrd_cnt c%0d got=%b exp=%b", c, ld_gnt, c == 5); end
      next_cycle(); #1;
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_withdraw();
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h400; cpu_wdata = 32'h1;
    ld_req = 1; ld_we = 0; ld_addr = 32'h500;
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) ld_req = 0;
      #1;
      $display("withdraw cycle %0d: ld_req=%b ld_gnt=%b", c, ld_req, ld_gnt);
      checks++; if (ld_gnt !== 1'b0 || mem_addr !== 32'h400) begin failures++; $display("FAIL wd_no_gnt c%0d got=%b/%h exp=0/00000400", c, ld_gnt, mem_addr); end
      next_cycle();
    end
    ld_req = 1;
    for (int c = 1; c <= 5; c++) begin
      #1;
      checks++; if (ld_gnt !== (c == 5)) begin failures++; $display("FAIL wd_cnt c%0d got=%b exp=%b", c, ld_gnt, c == 5); end
      next_cycle();
    end
    idle_inputs(); #1;
    checks++; if (ld_rvalid !== 1'b1) begin failures++; $display("FAIL wd_ld_rvalid got=%b exp=1", ld_rvalid); end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_starvation();
    test_loader_write();
    test_back_to_back();
    test_reset_after_read();
    test_withdraw();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
